lcd_msg_arbiter: RTL and testbench

//  Shares the 16-bit LCD message register between NREQ requesters, such as the PC,
//  the ALU result and a register-file tap. Arbitration is round-robin.

---
 rtl/lcd_msg_arbiter_if.sv | 38 +++
 rtl/lcd_msg_arbiter.sv | 138 +++++++++++++
 tb/tb_lcd_msg_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/lcd_msg_arbiter_if.sv
// ---------------------------------------------------------------------------
// lcd_msg_arbiter_if
// Bundle of request/message signals between the LCD message arbiter and its
// requesters.
//   iREQ     per-requester request level
//   iDATA    packed messages; requester i occupies [i*DW +: DW]
//   oACK     one-cycle pulse per requester when its data has been latched
//   oMSG     message currently shown on the LCD (registered)
//   oSRC     index of the requester that owns oMSG
//   oUPDATE  one-cycle pulse whenever oMSG is (re)loaded by a grant
//   oBUSY    high while a granted message is being held
// Modports: master = requester side (drives iREQ/iDATA),
//           slave  = arbiter side (drives the o* signals).
// ---------------------------------------------------------------------------
interface lcd_msg_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 16
);
    localparam int SW = $clog2(NREQ);

    logic [NREQ-1:0]    iREQ;
    logic [NREQ*DW-1:0] iDATA;
    logic [NREQ-1:0]    oACK;
    logic [DW-1:0]      oMSG;
    logic [SW-1:0]      oSRC;
    logic               oUPDATE;
    logic               oBUSY;

    modport master (
        output iREQ, iDATA,
        input  oACK, oMSG, oSRC, oUPDATE, oBUSY
    );

    modport slave (
        input  iREQ, iDATA,
        output oACK, oMSG, oSRC, oUPDATE, oBUSY
    );
endinterface

// File: rtl/lcd_msg_arbiter.sv
// ---------------------------------------------------------------------------
// lcd_msg_arbiter
// Shares one LCD message register between NREQ requesters using round-robin
// arbitration. Each granted message is held for HOLD_CYCLES clocks before
// another grant may replace it; the last message stays until the next grant.
// Ports:
//   iCLK    system clock, rising edge
//   iRST_N  asynchronous active-low reset
//   bus     lcd_msg_arbiter_if.slave (iREQ, iDATA in; oACK, oMSG, oSRC,
//           oUPDATE, oBUSY out, all outputs registered)
// ---------------------------------------------------------------------------
module lcd_msg_arbiter #(
    parameter int NREQ        = 4,
    parameter int DW          = 16,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    lcd_msg_arbiter_if.slave   bus
);
    localparam int SW = $clog2(NREQ);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  msg_q, msg_d;
    logic [SW-1:0]  src_q, src_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic           update_q, update_d;
    logic           busy_q, busy_d;

    logic [DW-1:0]  data_arr [NREQ];
    logic [SW-1:0]  sel;
    logic [SW-1:0]  cand;
    logic           found;
    logic           req_any;
    logic           grant;

    // Unpack the flat data bus so the winner can be picked by index.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign data_arr[gi] = bus.iDATA[gi*DW +: DW];
        end
    endgenerate

    // Round-robin select: first requester found scanning upward from ptr,
    // wrapping past NREQ-1 back to 0.
    always_comb begin
        sel     = '0;
        cand    = '0;
        found   = 1'b0;
        req_any = |bus.iREQ;
        for (int k = 0; k < NREQ; k++) begin
            cand = SW'((int'(ptr_q) + k) % NREQ);
            if (!found && bus.iREQ[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        msg_d    = msg_q;
        src_d    = src_q;
        ack_d    = '0;
        update_d = 1'b0;
        busy_d   = busy_q;
        grant    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_any) grant = 1'b1;
            end
            HOLD: begin
                // Requests are ignored until the hold counter expires; on the
                // expiring edge a pending request is granted with no bubble.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (req_any) begin
                    grant = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (grant) begin
            msg_d      = data_arr[sel];
            src_d      = sel;
            ack_d[sel] = 1'b1;
            update_d   = 1'b1;
            ptr_d      = (sel == SW'(NREQ - 1)) ? '0 : sel + 1'b1;
            // The grant cycle itself counts as the first held cycle.
            cnt_d      = CW'(HOLD_CYCLES - 1);
            state_d    = HOLD;
            busy_d     = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            msg_q    <= '0;
            src_q    <= '0;
            ack_q    <= '0;
            update_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            msg_q    <= msg_d;
            src_q    <= src_d;
            ack_q    <= ack_d;
            update_q <= update_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.oACK    = ack_q;
    assign bus.oMSG    = msg_q;
    assign bus.oSRC    = src_q;
    assign bus.oUPDATE = update_q;
    assign bus.oBUSY   = busy_q;
endmodule

// File: tb/tb_lcd_msg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lcd_msg_arbiter
// Bench for lcd_msg_arbiter: one instance with HOLD_CYCLES=4 and one with
// HOLD_CYCLES=1, both NREQ=4, DW=16. Per-cycle vectors are queued as expected
// results when driven and compared after the following rising edge.
// ---------------------------------------------------------------------------
module tb_lcd_msg_arbiter;
    typedef struct {
        logic [3:0]  req;
        logic [3:0]  ack;
        logic        upd;
        logic        busy;
        logic [15:0] msg;
        logic [1:0]  src;
    } vec_t;

    logic iCLK;
    logic iRST_N;

    lcd_msg_arbiter_if #(.NREQ(4), .DW(16)) bus_a ();
    lcd_msg_arbiter_if #(.NREQ(4), .DW(16)) bus_b ();

    lcd_msg_arbiter #(.NREQ(4), .DW(16), .HOLD_CYCLES(4)) dut_a (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus_a.slave)
    );

    lcd_msg_arbiter #(.NREQ(4), .DW(16), .HOLD_CYCLES(1)) dut_b (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .bus    (bus_b.slave)
    );

    int   checks = 0;
    int   errors = 0;
    int   vec_no = 0;
    bit   mon_on = 1'b0;
    vec_t exp_q[$];
    vec_t tbl_a[$];
    vec_t tbl_p[$];
    vec_t tbl_b[$];

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic [3:0] req, input logic [3:0] ack,
                                input logic upd, input logic busy,
                                input logic [15:0] msg, input logic [1:0] src);
        vec_t v;
        v.req = req; v.ack = ack; v.upd = upd; v.busy = busy;
        v.msg = msg; v.src = src;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s (vec %0d): got %h, expected %h", name, vec_no, act, exp_v);
        end
    endtask

    // oACK must be one-hot or zero in every cycle on both instances.
    always @(negedge iCLK) begin
        if (mon_on) begin
            checks++;
            if (!$onehot0(bus_a.oACK) || !$onehot0(bus_b.oACK)) begin
                errors++;
                $display("FAIL ack_onehot: got a=%b b=%b, expected one-hot or zero",
                         bus_a.oACK, bus_b.oACK);
            end
        end
    end

    task automatic apply(input vec_t v, input bit use_b);
        vec_t        e;
        logic [3:0]  a_ack;
        logic        a_upd, a_busy;
        logic [15:0] a_msg;
        logic [1:0]  a_src;
        @(negedge iCLK);
        if (use_b) bus_b.iREQ = v.req;
        else       bus_a.iREQ = v.req;
        exp_q.push_back(v);
        @(posedge iCLK);
        #1;
        if (use_b) begin
            a_ack = bus_b.oACK; a_upd = bus_b.oUPDATE; a_busy = bus_b.oBUSY;
            a_msg = bus_b.oMSG; a_src = bus_b.oSRC;
        end else begin
            a_ack = bus_a.oACK; a_upd = bus_a.oUPDATE; a_busy = bus_a.oBUSY;
            a_msg = bus_a.oMSG; a_src = bus_a.oSRC;
        end
        e = exp_q.pop_front();
        $display("vec %0d dut=%s req=%b ack=%b upd=%b busy=%b msg=%h src=%0d",
                 vec_no, use_b ? "b" : "a", v.req, a_ack, a_upd, a_busy, a_msg, a_src);
        chk("ack",    32'(a_ack),  32'(e.ack));
        chk("update", 32'(a_upd),  32'(e.upd));
        chk("busy",   32'(a_busy), 32'(e.busy));
        chk("msg",    32'(a_msg),  32'(e.msg));
        chk("src",    32'(a_src),  32'(e.src));
        vec_no++;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_msg"},    32'(bus_a.oMSG),    32'h0);
        chk({tag, "_src"},    32'(bus_a.oSRC),    32'h0);
        chk({tag, "_ack"},    32'(bus_a.oACK),    32'h0);
        chk({tag, "_update"}, 32'(bus_a.oUPDATE), 32'h0);
        chk({tag, "_busy"},   32'(bus_a.oBUSY),   32'h0);
    endtask

    initial begin
        // Single request, wrap from ptr=3, then full round-robin with each
        // winner dropping for one cycle after its ACK.
        tbl_a.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'h0000, 0));
        tbl_a.push_back(mk(4'b0100, 4'b0100, 1, 1, 16'hBEEF, 2));
        for (int i = 0; i < 3; i++) tbl_a.push_back(mk(4'b0000, 4'b0000, 0, 1, 16'hBEEF, 2));
        tbl_a.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'hBEEF, 2));
        tbl_a.push_back(mk(4'b1001, 4'b1000, 1, 1, 16'hD333, 3));
        for (int i = 0; i < 3; i++) tbl_a.push_back(mk(4'b0001, 4'b0000, 0, 1, 16'hD333, 3));
        tbl_a.push_back(mk(4'b0001, 4'b0001, 1, 1, 16'hA000, 0));
        for (int i = 0; i < 3; i++) tbl_a.push_back(mk(4'b0000, 4'b0000, 0, 1, 16'hA000, 0));
        tbl_a.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'hA000, 0));
        tbl_a.push_back(mk(4'b1111, 4'b0010, 1, 1, 16'h1234, 1));
        tbl_a.push_back(mk(4'b1101, 4'b0000, 0, 1, 16'h1234, 1));
        for (int i = 0; i < 2; i++) tbl_a.push_back(mk(4'b1111, 4'b0000, 0, 1, 16'h1234, 1));
        tbl_a.push_back(mk(4'b1111, 4'b0100, 1, 1, 16'hBEEF, 2));
        tbl_a.push_back(mk(4'b1011, 4'b0000, 0, 1, 16'hBEEF, 2));
        for (int i = 0; i < 2; i++) tbl_a.push_back(mk(4'b1111, 4'b0000, 0, 1, 16'hBEEF, 2));
        tbl_a.push_back(mk(4'b1111, 4'b1000, 1, 1, 16'hD333, 3));
        tbl_a.push_back(mk(4'b0111, 4'b0000, 0, 1, 16'hD333, 3));
        for (int i = 0; i < 2; i++) tbl_a.push_back(mk(4'b1111, 4'b0000, 0, 1, 16'hD333, 3));
        tbl_a.push_back(mk(4'b1111, 4'b0001, 1, 1, 16'hA000, 0));
        tbl_a.push_back(mk(4'b1110, 4'b0000, 0, 1, 16'hA000, 0));
        for (int i = 0; i < 2; i++) tbl_a.push_back(mk(4'b1111, 4'b0000, 0, 1, 16'hA000, 0));
        tbl_a.push_back(mk(4'b1111, 4'b0010, 1, 1, 16'h1234, 1));
        tbl_a.push_back(mk(4'b1101, 4'b0000, 0, 1, 16'h1234, 1));

        // After the mid-hold reset: idle stays cleared, ptr restarts at 0,
        // and a request withdrawn during HOLD gets no ACK.
        tbl_p.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'h0000, 0));
        tbl_p.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'h0000, 0));
        tbl_p.push_back(mk(4'b1111, 4'b0001, 1, 1, 16'hA000, 0));
        tbl_p.push_back(mk(4'b0010, 4'b0000, 0, 1, 16'hA000, 0));
        tbl_p.push_back(mk(4'b0010, 4'b0000, 0, 1, 16'hA000, 0));
        tbl_p.push_back(mk(4'b0000, 4'b0000, 0, 1, 16'hA000, 0));
        tbl_p.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'hA000, 0));
        tbl_p.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'hA000, 0));

        // HOLD_CYCLES=1: sole requester re-served every other cycle, then
        // back-to-back grants straight out of HOLD.
        for (int i = 0; i < 3; i++) begin
            tbl_b.push_back(mk(4'b0001, 4'b0001, 1, 1, 16'h5A5A, 0));
            tbl_b.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'h5A5A, 0));
        end
        tbl_b.push_back(mk(4'b0011, 4'b0010, 1, 1, 16'hC3C3, 1));
        tbl_b.push_back(mk(4'b0001, 4'b0001, 1, 1, 16'h5A5A, 0));
        tbl_b.push_back(mk(4'b0010, 4'b0010, 1, 1, 16'hC3C3, 1));
        tbl_b.push_back(mk(4'b0000, 4'b0000, 0, 0, 16'hC3C3, 1));

        bus_a.iREQ  = '0;
        bus_b.iREQ  = '0;
        bus_a.iDATA = {16'hD333, 16'hBEEF, 16'h1234, 16'hA000};
        bus_b.iDATA = {16'h0000, 16'h0000, 16'hC3C3, 16'h5A5A};
        iRST_N = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk_cleared("reset_init");
        @(negedge iCLK);
        iRST_N = 1'b1;
        mon_on = 1'b1;

        foreach (tbl_a[i]) apply(tbl_a[i], 1'b0);

        // Asynchronous reset in the middle of a hold with oMSG=1234.
        @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        chk_cleared("reset_async");
        @(posedge iCLK);
        #1;
        chk_cleared("reset_held");
        @(negedge iCLK);
        bus_a.iREQ = '0;
        iRST_N = 1'b1;

        foreach (tbl_p[i]) apply(tbl_p[i], 1'b0);
        foreach (tbl_b[i]) apply(tbl_b[i], 1'b1);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        mon_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
